// File: rtl/mem_arbiter.sv
// Two-port arbiter (uP16 CPU, Wishbone slave) in front of four 1K x 16 RAM banks.
// Every access runs IDLE -> ACC -> CAP -> DONE; all RAM controls are registered and active-low.
module mem_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic        soc_clk,
  input  logic        soc_rst_n,
  // Handshake: a requester holds its request (cpu_req, or wbs_cyc_i & wbs_stb_i)
  // with stable attributes until cpu_ready / wbs_ack_o, each a one-cycle pulse.
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  mem_csb,
  output logic        mem_web,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout0,
  input  logic [15:0] mem_dout1,
  input  logic [15:0] mem_dout2,
  input  logic [15:0] mem_dout3,
  output logic        arb_busy,
  output logic        arb_owner,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_CAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        bank_q, bank_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [3:0]        csb_q, csb_d;
  logic              web_q, web_d;
  logic [9:0]        addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [15:0]       wb_rdata_q, wb_rdata_d;
  logic              wb_ack_q, wb_ack_d;

  logic              wb_pend, cpu_pend, grant_wb, starve_full;
  logic              req_we, wb_masked;
  logic [11:0]       req_addr;
  logic [15:0]       req_din;
  logic [15:0]       bank_dout;
  logic              unused_bits;

  assign unused_bits = ^{wbs_adr_i[31:14], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign wb_pend     = wbs_cyc_i & wbs_stb_i;
  assign cpu_pend    = cpu_req;
  assign starve_full = (starve_q == CNT_W'(STARVE_MAX));
  assign grant_wb    = wb_pend & (~cpu_pend | starve_full);

  assign req_we   = grant_wb ? wbs_we_i          : cpu_we;
  assign req_addr = grant_wb ? wbs_adr_i[13:2]   : cpu_addr;
  assign req_din  = grant_wb ? wbs_dat_i[15:0]   : cpu_wdata;
  // A Wishbone write that does not cover the low halfword must not touch the RAM.
  assign wb_masked = grant_wb & wbs_we_i & (wbs_sel_i[1:0] != 2'b11);

  always_comb begin
    case (bank_q)
      2'd0:    bank_dout = mem_dout0;
      2'd1:    bank_dout = mem_dout1;
      2'd2:    bank_dout = mem_dout2;
      default: bank_dout = mem_dout3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bank_d      = bank_q;
    we_d        = we_q;
    starve_d    = starve_q;
    csb_d       = csb_q;
    web_d       = web_q;
    addr_d      = addr_q;
    din_d       = din_q;
    cpu_rdata_d = cpu_rdata_q;
    wb_rdata_d  = wb_rdata_q;
    cpu_ready_d = 1'b0;
    wb_ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!wb_pend) starve_d = '0;
        if (cpu_pend || wb_pend) begin
          owner_d = grant_wb;
          bank_d  = req_addr[11:10];
          we_d    = req_we;
          addr_d  = req_addr[9:0];
          din_d   = req_din;
          web_d   = ~req_we;
          csb_d   = wb_masked ? 4'hF : ~(4'b0001 << req_addr[11:10]);
          state_d = S_ACC;
          if (grant_wb) begin
            starve_d = '0;
          end else if (wb_pend && !starve_full) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      S_ACC: begin
        csb_d   = 4'hF;
        web_d   = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        if (!we_q) begin
          if (owner_q) wb_rdata_d  = bank_dout;
          else         cpu_rdata_d = bank_dout;
        end
        cpu_ready_d = ~owner_q;
        wb_ack_d    = owner_q & wb_pend;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge soc_rst_n) begin
    if (!soc_rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      bank_q      <= 2'd0;
      we_q        <= 1'b0;
      starve_q    <= '0;
      csb_q       <= 4'hF;
      web_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      wb_rdata_q  <= '0;
      wb_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bank_q      <= bank_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_ack_q    <= wb_ack_d;
    end
  end

  assign mem_csb   = csb_q;
  assign mem_web   = web_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign wbs_ack_o = wb_ack_q;
  assign wbs_dat_o = {16'h0000, wb_rdata_q};
  assign arb_busy  = (state_q != S_IDLE);
  assign arb_owner = owner_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four behavioural RAM banks, request drivers,
// and a response scoreboard keyed on {owner, read data}.
module tb_mem_arbiter;
  localparam int W = 17;

  logic        soc_clk = 1'b0;
  logic        soc_rst_n;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic [3:0]  mem_csb;
  logic        mem_web;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] ram_dout [4];
  logic        arb_busy, arb_owner;
  logic [1:0]  arb_state;

  mem_arbiter #(.STARVE_MAX(8), .CNT_W(4)) dut (
    .soc_clk(soc_clk), .soc_rst_n(soc_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout0(ram_dout[0]), .mem_dout1(ram_dout[1]), .mem_dout2(ram_dout[2]), .mem_dout3(ram_dout[3]),
    .arb_busy(arb_busy), .arb_owner(arb_owner), .arb_state(arb_state)
  );

  // ---------------- clock ----------------
  always #5 soc_clk = ~soc_clk;

  // ---------------- RAM banks ----------------
  function automatic logic [15:0] init_val(input logic [11:0] a);
    return {a[11:10], 4'hA, a[9:0]};
  endfunction

  logic [15:0] ram [4096];
  bit          ram_loaded = 1'b0;

  always @(posedge soc_clk) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_val(12'(a));
      ram_loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!mem_csb[b]) begin
          if (!mem_web) ram[{2'(b), mem_addr}] <= mem_din;
          else          ram_dout[b] <= ram[{2'(b), mem_addr}];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [15:0]  model [4096];
  logic [15:0]  last_cpu_rd, last_wb_rd;
  int           checks_total  = 0;
  int           checks_passed = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void push_exp(input logic owner, input logic we, input logic [11:0] a,
                                   input logic [15:0] wd, input logic [3:0] sel);
    logic [15:0] d;
    if (!we) begin
      d = model[a];
      if (owner) last_wb_rd = d;
      else       last_cpu_rd = d;
    end else begin
      d = owner ? last_wb_rd : last_cpu_rd;
      if (!owner || sel[1:0] == 2'b11) model[a] = wd;
    end
    exp_q.push_back({owner, d});
  endfunction

  always @(negedge soc_clk) begin
    if (cpu_ready && wbs_ack_o) begin
      check("ready_and_ack_together", 32'(cpu_ready & wbs_ack_o), 32'd0);
    end else if (cpu_ready || wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_owner", 32'(wbs_ack_o), 32'(mon_e[16]));
        check("resp_data", cpu_ready ? {16'h0, cpu_rdata} : wbs_dat_o, {16'h0, mon_e[15:0]});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cpu_op(input logic we, input logic [11:0] a, input logic [15:0] wd);
    int cyc;
    bit got;
    logic [3:0] exp_csb;
    logic       exp_web;
    @(negedge soc_clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    push_exp(1'b0, we, a, wd, 4'hF);
    exp_csb = ~(4'b0001 << a[11:10]);
    exp_web = ~we;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge soc_clk);
      cyc++;
      if (cyc == 1) begin
        check("cpu_acc_csb", 32'(mem_csb), 32'(exp_csb));
        check("cpu_acc_addr", 32'(mem_addr), 32'(a[9:0]));
        check("cpu_acc_web", 32'(mem_web), 32'(exp_web));
        check("cpu_acc_owner", 32'(arb_owner), 32'd0);
        if (we) check("cpu_acc_din", 32'(mem_din), 32'(wd));
      end
      if (cyc == 2) check("cpu_cap_csb", 32'(mem_csb), 32'hF);
      if (cpu_ready) got = 1'b1;
    end
    check("cpu_latency", 32'(cyc), 32'd3);
    cpu_req = 1'b0;
    @(negedge soc_clk);
    check("cpu_ready_width", 32'(cpu_ready), 32'd0);
  endtask

  task automatic wb_op(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int cyc;
    bit got;
    logic [3:0] exp_csb;
    logic       exp_web;
    @(negedge soc_clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    push_exp(1'b1, we, adr[13:2], dat[15:0], sel);
    exp_csb = (we && sel[1:0] != 2'b11) ? 4'hF : ~(4'b0001 << adr[13:12]);
    exp_web = ~we;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge soc_clk);
      cyc++;
      if (cyc == 1) begin
        check("wb_acc_csb", 32'(mem_csb), 32'(exp_csb));
        check("wb_acc_addr", 32'(mem_addr), 32'(adr[11:2]));
        check("wb_acc_web", 32'(mem_web), 32'(exp_web));
        check("wb_acc_owner", 32'(arb_owner), 32'd1);
      end
      if (cyc == 2) check("wb_cap_csb", 32'(mem_csb), 32'hF);
      if (wbs_ack_o) got = 1'b1;
    end
    check("wb_latency", 32'(cyc), 32'd3);
    check("wb_done_csb", 32'(mem_csb), 32'hF);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge soc_clk);
    check("wb_ack_width", 32'(wbs_ack_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cyc;
    soc_rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = '0; wbs_dat_i = '0;
    for (int a = 0; a < 4096; a++) model[a] = init_val(12'(a));
    last_cpu_rd = '0; last_wb_rd = '0;

    repeat (3) @(negedge soc_clk);
    check("rst_csb", 32'(mem_csb), 32'hF);
    check("rst_web", 32'(mem_web), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_wb_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_wb_dat", wbs_dat_o, 32'd0);
    check("rst_busy", 32'(arb_busy), 32'd0);
    check("rst_owner", 32'(arb_owner), 32'd0);
    check("rst_state", 32'(arb_state), 32'd0);
    soc_rst_n = 1'b1;

    // CPU write/read round trip, plus an untouched word in another bank
    cpu_op(1'b1, 12'h5A3, 16'hBEEF);
    cpu_op(1'b0, 12'h5A3, 16'h0000);
    cpu_op(1'b0, 12'h812, 16'h0000);

    // Wishbone write/read round trip, plus an untouched word in bank 2
    wb_op(1'b1, 32'h3000_0FFC, 32'h0000_1234, 4'hF);
    wb_op(1'b0, 32'h3000_0FFC, 32'h0, 4'hF);
    wb_op(1'b0, 32'h0000_2C08, 32'h0, 4'hF);

    // Simultaneous requests with the starvation counter at zero
    @(negedge soc_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h456;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_1000; wbs_sel_i = 4'hF;
    push_exp(1'b0, 1'b0, 12'h456, 16'h0, 4'hF);
    push_exp(1'b1, 1'b0, 12'h400, 16'h0, 4'hF);
    n = 0; cyc = 0;
    while (n < 2 && cyc < 40) begin
      @(negedge soc_clk);
      cyc++;
      if (cpu_ready) begin
        check("sim_owner_first", 32'(arb_owner), 32'd0);
        cpu_req = 1'b0; n++;
      end
      if (wbs_ack_o) begin
        check("sim_owner_second", 32'(arb_owner), 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; n++;
      end
    end
    check("sim_both_done", 32'(n), 32'd2);
    check("sim_cycles", 32'(cyc), 32'd7);

    // Wishbone write that misses the low halfword leaves the RAM untouched
    wb_op(1'b1, 32'h0000_0040, 32'hFFFF_5555, 4'b0001);
    wb_op(1'b0, 32'h0000_0040, 32'h0, 4'hF);

    // CPU drops its request during ACC: ready still pulses
    @(negedge soc_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0AB;
    push_exp(1'b0, 1'b0, 12'h0AB, 16'h0, 4'hF);
    @(negedge soc_clk);
    cpu_req = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge soc_clk);
      if (cpu_ready) n++;
    end
    check("cpu_drop_ready_count", 32'(n), 32'd1);

    // Wishbone drops cyc/stb during ACC: read completes but no ack
    @(negedge soc_clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_3004; wbs_sel_i = 4'hF;
    @(negedge soc_clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    last_wb_rd = model[12'hC01];
    n = 0;
    repeat (5) begin
      @(negedge soc_clk);
      if (wbs_ack_o) n++;
    end
    check("wb_drop_ack_count", 32'(n), 32'd0);
    check("wb_drop_idle", 32'(arb_busy), 32'd0);
    wb_op(1'b1, 32'h0000_3008, 32'h0000_7777, 4'hF);

    // Both held continuously: 8 CPU grants, 1 WB grant, repeated twice
    @(negedge soc_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_0800; wbs_sel_i = 4'hF;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) push_exp(1'b0, 1'b0, 12'h123, 16'h0, 4'hF);
      push_exp(1'b1, 1'b0, 12'h200, 16'h0, 4'hF);
    end
    n = 0; cyc = 0;
    while (n < 18 && cyc < 200) begin
      @(negedge soc_clk);
      cyc++;
      if (cpu_ready || wbs_ack_o) n++;
    end
    cpu_req = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("starve_responses", 32'(n), 32'd18);
    cpu_op(1'b0, 12'h124, 16'h0);

    // Reset asserted during ACC of a CPU write, then the CPU retries
    @(negedge soc_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h9C4; cpu_wdata = 16'hA5A5;
    @(negedge soc_clk);
    check("rst_acc_csb", 32'(mem_csb), 32'h0000_000B);
    #1 soc_rst_n = 1'b0;
    #1;
    check("rst_async_csb", 32'(mem_csb), 32'hF);
    check("rst_async_busy", 32'(arb_busy), 32'd0);
    check("rst_async_rdata", 32'(cpu_rdata), 32'd0);
    last_cpu_rd = '0; last_wb_rd = '0;
    n = 0;
    repeat (3) begin
      @(negedge soc_clk);
      if (cpu_ready) n++;
    end
    check("rst_no_ready", 32'(n), 32'd0);
    soc_rst_n = 1'b1;
    push_exp(1'b0, 1'b1, 12'h9C4, 16'hA5A5, 4'hF);
    n = 0; cyc = 0;
    while (n == 0 && cyc < 40) begin
      @(negedge soc_clk);
      cyc++;
      if (cpu_ready) n++;
    end
    check("rst_retry_latency", 32'(cyc), 32'd3);
    cpu_req = 1'b0;
    cpu_op(1'b0, 12'h9C4, 16'h0);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge soc_clk);
      cyc++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the four 1K x 16 OpenRAM banks between the uP16 CPU port and a Wishbone slave port used by the management SoC for memory load/inspect.
- Sequences each access as a fixed 4-state transaction: grant, chip-select, data capture, completion.
- All RAM control outputs are registered and active-low.
- Sits between the CPU/Wishbone fabric and the RAM macros; takes over the RAM-side muxing and bank decode.

Parameters:
- STARVE_MAX, 8: consecutive CPU grants allowed while a Wishbone request waits; the next grant is then forced to Wishbone.
- CNT_W, 4: width of the starvation counter. Requires 2^CNT_W > STARVE_MAX.

Ports:
- soc_clk  input  1  single clock for all logic.
- soc_rst_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held high until cpu_ready.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  12  [11:10] bank, [9:0] word.
- cpu_wdata  input  16  CPU write data.
- cpu_rdata  output  16  read data, valid while cpu_ready is high.
- cpu_ready  output  1  one-cycle completion pulse.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic handshake.
- wbs_sel_i  input  4  byte selects.
- wbs_adr_i  input  32  byte address; [13:2] maps to the 12-bit word address. Upstream logic decodes the base.
- wbs_dat_i  input  32  write data; [15:0] is used.
- wbs_ack_o  output  1  one-cycle acknowledge.
- wbs_dat_o  output  32  {16'h0, read data}.
- mem_csb  output  4  per-bank chip select, active low.
- mem_web  output  1  write enable, active low.
- mem_addr  output  10  word address.
- mem_din  output  16  write data.
- mem_dout0..mem_dout3  input  16 each  bank read data.
- arb_busy  output  1  high when the FSM is not in IDLE.
- arb_owner  output  1  owner of the current or last transaction (0 = CPU, 1 = WB).

Behaviour:
Reset (asynchronous, immediate):
- state = IDLE.
- mem_csb = 4'hF, mem_web = 1.
- mem_addr = 0, mem_din = 0.
- cpu_rdata = 0, cpu_ready = 0.
- wbs_ack_o = 0, wbs_dat_o = 0.
- starve count = 0, arb_busy = 0, arb_owner = 0.
- If reset asserts mid-transaction, the access is abandoned with no ready/ack; the requester retries after release.

Request definitions:
- wb_pend = wbs_cyc_i & wbs_stb_i.
- cpu_pend = cpu_req.

IDLE:
- Arbitration: CPU wins unless (wb_pend & starve == STARVE_MAX) or !cpu_pend.
- On grant, register the following, then go to ACC:
  - owner and bank.
  - mem_addr, mem_din.
  - mem_web = ~we.
  - mem_csb = ~(1 << bank).
- WB write with wbs_sel_i[1:0] != 2'b11: keep all mem_csb high (no RAM write), still complete normally through ACC/CAP/DONE and ack.

ACC (1 cycle):
- csb is held; the RAM samples at the end of this cycle.
- Next edge: mem_csb = 4'hF, mem_web = 1, go to CAP.

CAP (1 cycle):
- On a read, capture mem_dout[bank] into the owner's read register (cpu_rdata or wbs_dat_o[15:0]). Writes leave the read registers unchanged.
- Next edge: go to DONE.
- In the same edge, set cpu_ready = (owner == CPU), or wbs_ack_o = (owner == WB) & wbs_cyc_i & wbs_stb_i.

DONE (1 cycle):
- ready/ack is high for exactly this cycle, then cleared. Go to IDLE.
- Latency: grant edge to ready/ack high is 3 cycles; minimum request period is 4 cycles.

Starvation counter (updated on each IDLE grant):
- CPU grant while wb_pend: starve + 1, saturating at STARVE_MAX.
- WB grant: reset to 0.
- Any IDLE cycle with !wb_pend: reset to 0.

Requester drops mid-transaction:
- CPU drops cpu_req: the access still completes and cpu_ready still pulses.
- Wishbone drops cyc/stb: the access completes but ack is suppressed.

Other rules:
- Simultaneous requests with starve < STARVE_MAX: CPU is granted; Wishbone holds and is served in the next IDLE.
- Addresses cover the full 12-bit range, so there is no out-of-range case.

Test Plan:
- CPU write 16'hBEEF to 12'h5A3, then read it back: only mem_csb = 4'b1101 is low during ACC with mem_addr = 10'h1A3; the read returns cpu_rdata = 16'hBEEF with cpu_ready 3 cycles after grant.
- WB write 32'h0000_1234 to adr 32'h3000_0FFC (word 12'h3FF, bank 0), then read: wbs_dat_o = 32'h0000_1234; ack is one cycle wide; mem_csb = 4'b1110.
- CPU req held continuously with a WB read pending: exactly 8 CPU grants, then a WB grant, then CPU resumes; the counter is 0 after the WB grant.
- Simultaneous CPU and WB request from IDLE with starve = 0: CPU is granted first and WB is acked in the following transaction; arb_owner goes 0, then 1.
- WB write with wbs_sel_i = 4'b0001: mem_csb stays 4'hF throughout and ack still arrives; a later read of that word shows it unchanged.
- soc_rst_n pulled low during ACC of a CPU write: mem_csb is 4'hF immediately (asynchronously) and no cpu_ready occurs; after release, the CPU retries and completes normally.
